if_fetch_unit: RTL and testbench

//  IF stage, directly upstream of ID_module. Holds the PC, picks the next PC from ID redirects,

---
 rtl/if_fetch_unit_if.sv | 24 ++
 rtl/if_fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-side SRAM-like port: request/address handshake followed by a separate data return.
interface if_fetch_unit_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: PC selection, one-outstanding SRAM fetch with stale-data dropping, and a small
// output buffer feeding the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        EPC_sel,
    input  logic [31:0] EPC,
    input  logic        JumpReg,
    input  logic [31:0] PCSrc_reg,
    input  logic        Jump,
    input  logic [31:0] Jump_addr,
    input  logic        BranchD,
    input  logic [31:0] Branch_addr,
    if_fetch_unit_if.master sram,
    output logic [31:0] instr,
    output logic [31:0] pc_plus_4,
    output logic [31:0] PCin,
    output logic        if_valid
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic            redir_pend_q, redir_pend_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     head_instr_q, head_instr_d;
    logic [31:0]     head_pc_q, head_pc_d;
    logic [31:0]     head_pc4_q, head_pc4_d;
    logic [31:0]     buf_instr_q [DEPTH];
    logic [31:0]     buf_instr_d [DEPTH];
    logic [31:0]     buf_pc_q    [DEPTH];
    logic [31:0]     buf_pc_d    [DEPTH];

    logic            redirect;
    logic [31:0]     target;
    logic            push;
    logic            pop;

    always_comb begin
        redirect = EPC_sel | JumpReg | Jump | BranchD;
        if (EPC_sel)      target = EPC;
        else if (JumpReg) target = PCSrc_reg;
        else if (Jump)    target = Jump_addr;
        else              target = Branch_addr;
    end

    assign if_valid       = (count_q != '0);
    assign pop            = if_valid & ~StallF & ~redirect;
    assign sram.inst_addr = {req_addr_q[31:2], 2'b00};

    // The SRAM address comes from req_addr_q, not pc_q, so a redirect during REQ leaves the
    // pending address untouched while pc_q already moves to the target.
    always_comb begin
        state_d       = state_q;
        pc_d          = redirect ? target : pc_q;
        req_addr_d    = req_addr_q;
        redir_pend_d  = redir_pend_q;
        push          = 1'b0;
        sram.inst_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect || (int'(count_q) - int'(pop) < DEPTH)) begin
                    state_d    = REQ;
                    req_addr_d = pc_d;
                end
            end
            REQ: begin
                sram.inst_req = 1'b1;
                if (sram.inst_addr_ok) begin
                    redir_pend_d = 1'b0;
                    if (redirect || redir_pend_q) begin
                        state_d = DROP;
                    end else begin
                        state_d = WAIT;
                        pc_d    = pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    redir_pend_d = 1'b1;
                end
            end
            WAIT: begin
                if (sram.inst_data_ok) begin
                    if (redirect) begin
                        state_d    = REQ;
                        req_addr_d = pc_d;
                    end else begin
                        push = 1'b1;
                        if (int'(count_q) + 1 - int'(pop) < DEPTH) begin
                            state_d    = REQ;
                            req_addr_d = pc_d;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (sram.inst_data_ok) begin
                    state_d    = REQ;
                    req_addr_d = pc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        if (push) begin
            buf_instr_d[wr_ptr_q] = sram.inst_rdata;
            buf_pc_d[wr_ptr_q]    = req_addr_q;
        end
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end
        head_instr_d = if_valid ? buf_instr_q[rd_ptr_q] : head_instr_q;
        head_pc_d    = if_valid ? buf_pc_q[rd_ptr_q] : head_pc_q;
        head_pc4_d   = if_valid ? buf_pc_q[rd_ptr_q] + 32'd4 : head_pc4_q;
    end

    // Outputs fall back to the last head seen so ID sees a steady value while if_valid is low.
    assign instr     = if_valid ? buf_instr_q[rd_ptr_q] : head_instr_q;
    assign PCin      = if_valid ? buf_pc_q[rd_ptr_q] : head_pc_q;
    assign pc_plus_4 = if_valid ? buf_pc_q[rd_ptr_q] + 32'd4 : head_pc4_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            redir_pend_q <= 1'b0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            head_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            redir_pend_q <= redir_pend_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            head_pc4_q   <= head_pc4_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count_q == CW'(DEPTH))));
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: SRAM responder, PC-sequence scoreboard and directed redirect/stall/reset cases.
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        StallF = 1'b0;
    logic        EPC_sel = 1'b0, JumpReg = 1'b0, Jump = 1'b0, BranchD = 1'b0;
    logic [31:0] EPC = '0, PCSrc_reg = '0, Jump_addr = '0, Branch_addr = '0;
    logic [31:0] instr, pc_plus_4, PCin;
    logic        if_valid;

    if_fetch_unit_if sram ();

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .StallF(StallF),
        .EPC_sel(EPC_sel), .EPC(EPC), .JumpReg(JumpReg), .PCSrc_reg(PCSrc_reg),
        .Jump(Jump), .Jump_addr(Jump_addr), .BranchD(BranchD), .Branch_addr(Branch_addr),
        .sram(sram),
        .instr(instr), .pc_plus_4(pc_plus_4), .PCin(PCin), .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pops     = 0;
    int data_lat = 1;
    logic aok_en = 1'b1;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic restart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Scoreboard: every consumed head must continue the expected PC sequence.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (EPC_sel | JumpReg | Jump | BranchD) begin
                    restart(EPC_sel ? EPC : JumpReg ? PCSrc_reg : Jump ? Jump_addr : Branch_addr);
                end else if (if_valid && !StallF) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc", PCin, e);
                        chk("sb_instr", instr, mkdata(e));
                        chk("sb_pc4", pc_plus_4, e + 32'd4);
                        pops++;
                    end
                end
            end
        end
    end

    // SRAM responder: addr_ok from aok_en, data returned data_lat cycles after acceptance.
    initial begin
        logic        acc, hold_chk, pend;
        logic [31:0] a, hold_addr, paddr;
        int          cnt;
        hold_chk = 1'b0; pend = 1'b0; cnt = 0; paddr = '0; hold_addr = '0;
        sram.inst_addr_ok = 1'b0;
        sram.inst_data_ok = 1'b0;
        sram.inst_rdata   = '0;
        forever begin
            @(negedge clk);
            if (rst && hold_chk && sram.inst_req) chk("addr_stable", sram.inst_addr, hold_addr);
            hold_chk  = rst && sram.inst_req && !sram.inst_addr_ok;
            hold_addr = sram.inst_addr;
            acc       = rst && sram.inst_req && sram.inst_addr_ok;
            a         = sram.inst_addr;
            @(posedge clk);
            #1;
            if (acc) begin
                pend  = 1'b1;
                paddr = a;
                cnt   = data_lat;
            end
            sram.inst_data_ok = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    sram.inst_data_ok = 1'b1;
                    sram.inst_rdata   = mkdata(paddr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            sram.inst_addr_ok = aok_en;
        end
    end

    task automatic wait_req(input string tag);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (sram.inst_req) ok = 1;
        end
        if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_acc(input string tag, input bit need_valid);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (sram.inst_req && sram.inst_addr_ok && (!need_valid || if_valid)) ok = 1;
        end
        if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (if_valid) ok = 1;
        end
        if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_idle;
        @(posedge clk); #2;
        EPC_sel = 1'b0; JumpReg = 1'b0; Jump = 1'b0; BranchD = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        #200000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        restart(RESET_PC);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req", {31'd0, sram.inst_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pcin", PCin, 32'd0);
        chk("rst_pc4", pc_plus_4, 32'd0);
        rst = 1'b1;

        wait_req("first_req");
        chk("first_addr", sram.inst_addr, RESET_PC);
        repeat (20) @(posedge clk);

        // Stalled ID: buffer fills and fetching stops with the head held.
        #2; StallF = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        held = PCin;
        chk("stall_valid", {31'd0, if_valid}, 32'd1);
        repeat (2) @(negedge clk);
        chk("stall_req", {31'd0, sram.inst_req}, 32'd0);
        chk("stall_hold", PCin, held);
        @(posedge clk); #2; StallF = 1'b0;
        repeat (10) @(posedge clk);

        // Taken branch while a request waits for data.
        data_lat = 3;
        wait_acc("br_acc", 1'b0);
        @(posedge clk); #2;
        Branch_addr = 32'hBFC0_0100; BranchD = 1'b1;
        pulse_idle();
        data_lat = 1;
        wait_valid("br_valid");
        chk("br_target", PCin, 32'hBFC0_0100);
        repeat (4) @(posedge clk);

        // Simultaneous redirects: EPC wins.
        #2;
        EPC = 32'h8000_0180; Jump_addr = 32'h0040_0000; Branch_addr = 32'h1234_5678;
        EPC_sel = 1'b1; Jump = 1'b1; BranchD = 1'b1;
        pulse_idle();
        wait_valid("epc_valid");
        chk("epc_target", PCin, 32'h8000_0180);
        repeat (4) @(posedge clk);

        // JumpReg in the same cycle as data_ok.
        data_lat = 2;
        wait_acc("jr_acc", 1'b0);
        @(posedge clk);
        @(posedge clk); #2;
        PCSrc_reg = 32'hBFC0_0200; JumpReg = 1'b1;
        pulse_idle();
        data_lat = 1;
        wait_valid("jr_valid");
        chk("jr_target", PCin, 32'hBFC0_0200);
        repeat (4) @(posedge clk);

        // Redirect while the request is not yet accepted.
        aok_en = 1'b0;
        repeat (2) @(posedge clk);
        wait_req("hold_req");
        held = sram.inst_addr;
        @(posedge clk); #2;
        PCSrc_reg = 32'hBFC0_0300; JumpReg = 1'b1;
        pulse_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_addr", sram.inst_addr, held);
            chk("hold_reqhi", {31'd0, sram.inst_req}, 32'd1);
        end
        aok_en = 1'b1;
        wait_valid("hold_valid");
        chk("hold_target", PCin, 32'hBFC0_0300);
        repeat (4) @(posedge clk);

        // Reset while waiting for data with a valid head in the buffer.
        StallF = 1'b1;
        data_lat = 3;
        wait_acc("rst_acc", 1'b1);
        @(posedge clk); #2;
        chk("pre_rst_valid", {31'd0, if_valid}, 32'd1);
        rst = 1'b0;
        restart(RESET_PC);
        #1;
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_req", {31'd0, sram.inst_req}, 32'd0);
        chk("mid_rst_pcin", PCin, 32'd0);
        StallF = 1'b0;
        repeat (2) @(posedge clk);
        #2; rst = 1'b1; data_lat = 1;
        wait_req("post_rst_req");
        chk("post_rst_addr", sram.inst_addr, RESET_PC);
        wait_valid("post_rst_valid");
        chk("post_rst_pcin", PCin, RESET_PC);
        repeat (20) @(posedge clk);

        chk("pops_total", {31'd0, pops >= 12}, 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
